// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and data accesses onto a byte-wide
// single-port RAM, moving 1/2/4 bytes per transaction one byte per cycle.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [AW-1:0]   base_q, base_d;
  logic            we_q, we_d, own_if_q, own_if_d;
  logic [DW-1:0]   wdata_q, wdata_d, res_q, res_d;
  logic            if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [DW-1:0]   if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            ram_we_q, ram_we_d, busy_q, busy_d;
  logic [BW-1:0]   ram_dout_q, ram_dout_d;

  logic            grant_mem, grant_if, cancel, last;
  logic [1:0]      rd_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      own_if_q    <= 1'b0;
      wdata_q     <= '0;
      res_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      we_q        <= we_d;
      own_if_q    <= own_if_d;
      wdata_q     <= wdata_d;
      res_q       <= res_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_dout_q  <= ram_dout_d;
      busy_q      <= busy_d;
    end
  end

  // Grants wait out the done cycle so the requester can drop its request.
  always_comb begin
    grant_mem = !if_done_q && !mem_done_q && mem_req;
    grant_if  = !if_done_q && !mem_done_q && !mem_req && if_req && !if_cancel;
    cancel    = own_if_q && if_cancel;
    last      = we_q ? (cnt_q == len_q - CW'(1)) : (cnt_q == len_q);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (grant_mem || grant_if) state_d = ACCESS;
      ACCESS:  if (cancel || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; RAM signals are set up one cycle ahead.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    we_d        = we_q;
    own_if_d    = own_if_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    rd_idx      = 2'(cnt_q - CW'(1));
    if (state_q == IDLE && (grant_mem || grant_if)) begin
      cnt_d    = '0;
      base_d   = grant_mem ? mem_addr : if_addr;
      we_d     = grant_mem && mem_we;
      wdata_d  = mem_wdata;
      own_if_d = !grant_mem;
      res_d    = '0;
      if (!grant_mem)             len_d = CW'(4);
      else if (mem_size == 2'b00) len_d = CW'(1);
      else if (mem_size == 2'b01) len_d = CW'(2);
      else                        len_d = CW'(4);
    end else if (state_q == ACCESS && !cancel) begin
      cnt_d = cnt_q + CW'(1);
      if (!we_q && cnt_q != '0) res_d[{rd_idx, 3'b000} +: BW] = ram_din;
      if (last) begin
        if (own_if_q) begin
          if_done_d = 1'b1;
          if_data_d = res_d;
        end else begin
          mem_done_d = 1'b1;
          if (!we_q) mem_rdata_d = res_d;
        end
      end
    end
    if (state_d == ACCESS && cnt_d < len_d) begin
      ram_addr_d = base_d + AW'(cnt_d);
      ram_we_d   = we_d;
      ram_dout_d = wdata_d[{cnt_d[1:0], 3'b000} +: BW];
    end
    busy_d = (state_d != IDLE);
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_dout  = ram_dout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed transactions against a byte-array
// reference memory with latency and address-sequence expectations.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        if_done, mem_done, ram_we, busy;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
    .ram_din(ram_din), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] d = '0;
    for (int i = 0; i < n; i++) d = d | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return d;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Single-port RAM: synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] = ram_dout;
    ram_din <= ram_rd(ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input bit is_if, input bit we_in, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
    int n, lat, wes;
    bit seen, we;
    logic [31:0] exp;
    we   = we_in && !is_if;
    n    = is_if ? 4 : nbytes(size);
    lat  = we ? n + 1 : n + 2;
    exp  = ref_read(addr, n);
    seen = 1'b0;
    wes  = 0;
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      mem_addr = addr; mem_we = we; mem_size = size; mem_wdata = wdata; mem_req = 1'b1;
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      next_cycle();
      if (ram_we) wes++;
      if (k <= n) begin
        check("ram_addr", ram_addr, addr + 32'(k - 1));
        check("ram_we", 32'(ram_we), 32'(we));
        if (we) check("ram_dout", 32'(ram_dout), 32'(8'(wdata >> (8 * (k - 1)))));
      end else if (k == n + 1 && !we) begin
        check("ram_addr_hold", ram_addr, addr + 32'(n - 1));
      end
      if (if_done || mem_done) begin
        seen = 1'b1;
        check("latency", 32'(k), 32'(lat));
        check("done_owner", {30'd0, if_done, mem_done}, is_if ? 32'd2 : 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        if (!we) check("rdata", is_if ? if_data : mem_rdata, exp);
        if_req = 1'b0;
        mem_req = 1'b0;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      if_req = 1'b0;
      mem_req = 1'b0;
    end
    check("we_cycles", 32'(wes), we ? 32'(n) : 32'd0);
    if (we) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
    next_cycle();
    check("done_one_cycle", {30'd0, if_done, mem_done}, 32'd0);
  endtask

  initial begin
    int md, id, cnt;
    logic [31:0] wd;
    rst = 1'b0;
    if_req = 1'b0; if_cancel = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = '0; mem_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      ram_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
      ref_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
    end
    #1;
    check("rst_outs", {if_done, mem_done, ram_we, busy, ram_dout, ram_addr[7:0], 12'd0}, 32'd0);
    check("rst_data", if_data | mem_rdata | ram_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word read with known contents, then half write and readback.
    run_txn(1'b0, 1'b0, 32'h100, 2'b10, 32'h0);
    check("known_word", mem_rdata, 32'h44332211);
    run_txn(1'b0, 1'b1, 32'h200, 2'b01, 32'hABCD1234);
    check("ram_200", 32'(ram_rd(32'h200)), 32'h34);
    check("ram_201", 32'(ram_rd(32'h201)), 32'h12);
    run_txn(1'b0, 1'b0, 32'h200, 2'b01, 32'h0);
    check("readback_half", mem_rdata, 32'h00001234);

    // Simultaneous requests: data side wins, fetch granted after the gap.
    if_addr = 32'h300; if_req = 1'b1;
    mem_addr = 32'h100; mem_we = 1'b0; mem_size = 2'b10; mem_req = 1'b1;
    md = 0; id = 0;
    for (int k = 1; k <= 20 && id == 0; k++) begin
      next_cycle();
      if (mem_done) begin
        md = k;
        check("cc_mrdata", mem_rdata, 32'h44332211);
        mem_req = 1'b0;
      end
      if (k == 7) check("cc_gap", 32'(busy), 32'd0);
      if (k == 8) check("cc_if_grant", 32'(busy), 32'd1);
      if (if_done) begin
        id = k;
        check("cc_idata", if_data, ref_read(32'h300, 4));
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("cc_mem_lat", 32'(md), 32'd6);
    check("cc_if_lat", 32'(id), 32'd13);
    next_cycle();

    // Fetch cancelled in its second access cycle.
    if_addr = 32'h400; if_req = 1'b1; cnt = 0;
    next_cycle();
    cnt += int'(ram_we);
    check("cx_busy", 32'(busy), 32'd1);
    next_cycle();
    cnt += int'(ram_we);
    if_cancel = 1'b1; if_req = 1'b0;
    next_cycle();
    check("cx_idle", 32'(busy), 32'd0);
    if_cancel = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cnt += int'(ram_we) + int'(if_done);
      next_cycle();
    end
    check("cx_no_done_no_we", 32'(cnt), 32'd0);

    // Cancel while idle blocks the fetch grant for that cycle only.
    if_addr = 32'h404; if_req = 1'b1; if_cancel = 1'b1;
    next_cycle();
    check("cx_idle_block", 32'(busy), 32'd0);
    if_cancel = 1'b0;
    next_cycle();
    check("cx_grant_after", 32'(busy), 32'd1);
    cnt = 0;
    for (int k = 0; k < 12 && cnt == 0; k++) begin
      next_cycle();
      if (if_done) cnt = 1;
    end
    check("cx_fetch_done", 32'(cnt), 32'd1);
    check("cx_fetch_data", if_data, ref_read(32'h404, 4));
    if_req = 1'b0;
    next_cycle();

    // Cancel has no effect on a data access.
    if_cancel = 1'b1;
    run_txn(1'b0, 1'b0, 32'h102, 2'b01, 32'h0);
    if_cancel = 1'b0;

    // Reset in the third cycle of a word write: two bytes land, no done.
    wd = $urandom;
    mem_addr = 32'h500; mem_we = 1'b1; mem_size = 2'b10; mem_wdata = wd; mem_req = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    check("rw_we_before", 32'(ram_we), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_outs", {if_done, mem_done, ram_we, busy, ram_dout, 20'd0}, 32'd0);
    check("rw_data", if_data | mem_rdata | ram_addr, 32'd0);
    mem_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    ref_mem[32'h500] = wd[7:0];
    ref_mem[32'h501] = wd[15:8];
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      cnt += int'(mem_done) + int'(if_done) + int'(busy);
    end
    check("rw_quiet", 32'(cnt), 32'd0);
    run_txn(1'b0, 1'b0, 32'h500, 2'b10, 32'h0);

    // Address wrap across the top of memory.
    run_txn(1'b1, 1'b0, 32'hFFFFFFFE, 2'b10, 32'h0);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 23));
      run_txn(1'($urandom_range(0, 2) == 0), 1'($urandom), a,
              2'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately.
REQ-003 if_req  input  1  instruction-fetch request (4-byte read); held until if_done or if_cancel.
REQ-004 if_addr  input  32  fetch byte address.
REQ-005 if_cancel  input  1  abort in-flight or pending fetch (branch flush).
REQ-006 if_done  output  1  one-cycle pulse: fetch complete, if_data valid.
REQ-007 if_data  output  32  fetched word, little-endian.
REQ-008 mem_req  input  1  data-access request; held until mem_done.
REQ-009 mem_we  input  1  1=write, 0=read.
REQ-010 mem_addr  input  32  data byte address.
REQ-011 mem_size  input  2  00=byte, 01=half, 10=word, 11=word.
REQ-012 mem_wdata  input  32  write data; low N bytes used.
REQ-013 mem_done  output  1  one-cycle pulse: data access complete.
REQ-014 mem_rdata  output  32  read data, zero-extended above N bytes.
REQ-015 ram_addr  output  32  byte address to single-port RAM.
REQ-016 ram_we  output  1  RAM byte write enable.
REQ-017 ram_dout  output  8  byte written to RAM.
REQ-018 ram_din  input  8  RAM read byte; valid one cycle after its address is driven.
REQ-019 busy  output  1  1 whenever state is not IDLE.

Function
REQ-020 States SHALL be IDLE and ACCESS; byte counter cnt (3 bits); latched base address, size N (1/2/4), we, wdata, owner (IF/MEM).
REQ-021 In IDLE, with done outputs low, grant SHALL be fixed priority: mem_req over if_req; granted request latched at the edge, state->ACCESS, cnt=0.
REQ-022 No grant SHALL occur in a cycle where if_done or mem_done is high (one-cycle gap; requester drops req during done).
REQ-023 In ACCESS with cnt<N: ram_addr=base+cnt (32-bit modulo, 0xFFFFFFFF+1=0), ram_we=we, ram_dout=wdata byte cnt.
REQ-024 Reads: ram_din sampled in cycle cnt=k+1 SHALL be stored as result byte k; read ACCESS lasts N+1 cycles (cnt 0..N); in cnt=N cycle ram_we=0, ram_addr holds last value.
REQ-025 Writes: ACCESS SHALL last N cycles (cnt 0..N-1); ram_we high exactly N cycles.
REQ-026 After last ACCESS cycle, state->IDLE and owner's done SHALL pulse high for exactly one cycle with data registered.
REQ-027 Latency from req-sampled cycle 0: word read done cycle 6, half read 4, byte read 3, word write 5, half write 3, byte write 2.
REQ-028 Request inputs changing during ACCESS SHALL be ignored.
REQ-029 if_cancel high while owner=IF in ACCESS SHALL return to IDLE at next edge with no if_done; if_cancel in IDLE suppresses IF grant that cycle.
REQ-030 if_cancel SHALL have no effect on a MEM-owned access.
REQ-031 Outside ACCESS, ram_we SHALL be 0.

Reset
REQ-032 On rst=0: state IDLE, cnt 0, ram_we 0, ram_addr 0, ram_dout 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0, busy 0, asynchronously.
REQ-033 Reset mid-access SHALL abandon the transaction; no done pulse after release; partial writes not rolled back.
REQ-034 First grant possible at the first rising edge after rst returns high.

Verification
REQ-035 MEM word read 0x100, RAM 0x100..0x103 = 11,22,33,44 -> mem_done cycle 6, mem_rdata 0x44332211, ram_we never high.
REQ-036 MEM half write 0xABCD1234 @0x200 -> 0x34@0x200, 0x12@0x201, ram_we high 2 cycles, mem_done cycle 3.
REQ-037 if_req and mem_req both high cycle 0 -> MEM word read done cycle 6, no grant cycle 6, IF granted cycle 7, if_done cycle 13.
REQ-038 IF fetch, if_cancel in 2nd ACCESS cycle -> busy 0 next cycle, no if_done, ram_we never high.
REQ-039 rst=0 during 3rd cycle of word write -> ram_we 0 immediately, all outputs 0, no mem_done after release.
REQ-040 IF fetch @0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
